fetch_buffer8w: RTL

- Instruction fetch buffer that produces the 8-wide instruction/PC bundles consumed by the decode stage.
- Accepts up to 8 contiguous 32-bit instruction words per cycle from the fetch unit and stores them in a circular queue.
- Presents the oldest up-to-8 entries to decode, with a valid/ready handshake and a pipeline flush.
- Sits between I-cache fetch and the 8-wide decoder.

---
 rtl/fetch_buffer8w.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_buffer8w.sv
// Circular instruction queue between I-cache fetch and the 8-wide decoder.
// Accepts up to WIDTH contiguous words per cycle and presents the oldest up-to-WIDTH entries.
module fetch_buffer8w #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_valid_i,
  input  logic [3:0]                    fetch_cnt_i,
  input  logic [WIDTH-1:0][31:0]        fetch_instr_i,
  input  logic [63:0]                   fetch_pc_i,
  input  logic                          fetch_fault_i,
  output logic                          fetch_ready_o,
  output logic [WIDTH-1:0]              dec_valid_o,
  output logic [WIDTH-1:0][31:0]        dec_instr_o,
  output logic [WIDTH-1:0][63:0]        dec_pc_o,
  output logic [WIDTH-1:0]              dec_fault_o,
  input  logic                          dec_ready_i,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic [3:0]    n_out;
  logic          cnt_ok;
  logic          push;
  logic          pop;

  logic [WIDTH-1:0]         wr_en;
  logic [WIDTH-1:0][PW-1:0] wr_addr;
  logic [WIDTH-1:0][63:0]   wr_pc;
  logic [WIDTH-1:0][PW-1:0] rd_addr;

  assign n_out         = (count_reg >= CW'(WIDTH)) ? 4'(WIDTH) : count_reg[3:0];
  assign cnt_ok        = (fetch_cnt_i != 4'd0) && (fetch_cnt_i <= 4'(WIDTH));
  // Readiness looks only at the registered count so it never depends on decode.
  assign fetch_ready_o = (count_reg <= CW'(DEPTH - WIDTH));
  assign push          = fetch_valid_i && fetch_ready_o && cnt_ok && !flush_i;
  assign pop           = dec_ready_i && (n_out != 4'd0) && !flush_i;
  assign count_o       = count_reg;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = tail_reg + PW'(fetch_cnt_i);
      if (pop)  head_next = head_reg + PW'(n_out);
      count_next = count_reg + (push ? CW'(fetch_cnt_i) : CW'(0))
                             - (pop  ? CW'(n_out)       : CW'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign wr_en[gi]   = push && (fetch_cnt_i > 4'(gi));
      assign wr_addr[gi] = tail_reg + PW'(gi);
      assign wr_pc[gi]   = fetch_pc_i + 64'(4 * gi);

      // Pointer arithmetic wraps modulo DEPTH, so bundles read across the end seamlessly.
      assign rd_addr[gi]     = head_reg + PW'(gi);
      assign dec_valid_o[gi] = (n_out > 4'(gi));
      assign dec_instr_o[gi] = dec_valid_o[gi] ? instr_mem[rd_addr[gi]] : 32'd0;
      assign dec_pc_o[gi]    = dec_valid_o[gi] ? pc_mem[rd_addr[gi]]    : 64'd0;
      assign dec_fault_o[gi] = dec_valid_o[gi] ? fault_mem[rd_addr[gi]] : 1'b0;
    end
  endgenerate

  // Entry storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (wr_en[k]) begin
        instr_mem[wr_addr[k]] <= fetch_instr_i[k];
        pc_mem[wr_addr[k]]    <= wr_pc[k];
        fault_mem[wr_addr[k]] <= fetch_fault_i;
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_reg <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && !fetch_ready_o));
  a_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
                                  (dec_valid_o & (dec_valid_o + WIDTH'(1))) == '0);

endmodule
